// File: rtl/stopwatch_pkg.sv
// Shared definitions for the key_event debouncer: per-key FSM encoding and ms-tick divider.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StHeld,
        StLong,
        StDbRelease
    } key_state_e;

    localparam int unsigned TICKS_PER_SEC = 1000;

    // Number of system clocks per 1 ms tick.
    function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
        return clk_hz / TICKS_PER_SEC;
    endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: 2-flop synchroniser, debounce/hold FSM and event pulses.
// Auto-repeat logic exists only when KEY_REPEAT_EN is defined.
module key_event_ch
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_MS   = 200
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HoldW = $clog2(LONG_MS + 1);

    logic             sync1_q, sync_q;
    key_state_e       state_q, state_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             was_long_q, was_long_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            was_long_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            was_long_q <= was_long_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        was_long_d = was_long_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                db_cnt_d = '0;
                if (sync_q) state_d = StDbPress;
            end
            StDbPress: begin
                if (!sync_q) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else if (tick) begin
                    if (db_cnt_q == DbW'(DEBOUNCE_MS - 1)) begin
                        state_d    = StHeld;
                        level_d    = 1'b1;
                        press_d    = 1'b1;
                        db_cnt_d   = '0;
                        hold_cnt_d = '0;
                    end else if (db_cnt_q < DbW'(DEBOUNCE_MS)) begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end
            StHeld: begin
                if (!sync_q) begin
                    state_d    = StDbRelease;
                    was_long_d = 1'b0;
                    hold_cnt_d = '0;
                    db_cnt_d   = '0;
                end else if (tick) begin
                    if (hold_cnt_q == HoldW'(LONG_MS - 1)) begin
                        state_d    = StLong;
                        long_d     = 1'b1;
                        hold_cnt_d = HoldW'(LONG_MS);
                    end else if (hold_cnt_q < HoldW'(LONG_MS)) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            StLong: begin
                if (!sync_q) begin
                    state_d    = StDbRelease;
                    was_long_d = 1'b1;
                    hold_cnt_d = '0;
                    db_cnt_d   = '0;
                end
            end
            StDbRelease: begin
                // A bounce back to 1 resumes the hold without re-announcing it.
                if (sync_q) begin
                    state_d    = was_long_q ? StLong : StHeld;
                    hold_cnt_d = '0;
                    db_cnt_d   = '0;
                end else if (tick) begin
                    if (db_cnt_q == DbW'(DEBOUNCE_MS - 1)) begin
                        state_d   = StIdle;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        db_cnt_d  = '0;
                    end else if (db_cnt_q < DbW'(DEBOUNCE_MS)) begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_MS + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_q, rep_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    // Count only while staying in LONG; the entry tick is not part of the first period.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_d     = 1'b0;
        if (state_q == StLong && state_d == StLong) begin
            if (tick) begin
                if (rep_cnt_q == RepW'(REPEAT_MS - 1)) begin
                    rep_cnt_d = '0;
                    rep_d     = 1'b1;
                end else if (rep_cnt_q < RepW'(REPEAT_MS)) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end else begin
            rep_cnt_d = '0;
        end
    end

    assign key_repeat = rep_q;
`else
    assign key_repeat = 1'b0;
`endif

    assign key_level   = level_q;
    assign press       = press_q;
    assign key_release = release_q;
    assign long_press  = long_q;

endmodule

// File: rtl/key_event.sv
// N-key debouncer with press/release/long-press events; auto-repeat under KEY_REPEAT_EN.
// release/repeat are reserved words, so those ports are named key_release/key_repeat.
module key_event
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned N_KEYS      = 5,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int unsigned Div  = ms_tick_div(CLK_HZ);
    localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

    if (Div == 0 || DEBOUNCE_MS == 0 || LONG_MS == 0 || REPEAT_MS == 0) begin : g_param_check
        $error("key_event: CLK_HZ must be >= 1000 and all *_MS parameters nonzero");
    end

    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    assign tick  = (div_q == DivW'(Div - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_event_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_MS   (REPEAT_MS)
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_raw     (key_in[i]),
            .key_level   (key_level[i]),
            .press       (press[i]),
            .key_release (key_release[i]),
            .long_press  (long_press[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: expected events are queued with cycle windows
// when stimulus is driven and matched as the DUT pulses.
module tb_key_event;

    localparam int unsigned CLK_HZ = 10_000;
    localparam int unsigned NK     = 5;
    localparam int          CPM    = 10;   // clocks per ms

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, press, key_release, long_press, key_repeat;

    key_event #(
        .CLK_HZ      (CLK_HZ),
        .N_KEYS      (NK),
        .DEBOUNCE_MS (20),
        .LONG_MS     (100),
        .REPEAT_MS   (30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .press       (press),
        .key_release (key_release),
        .long_press  (long_press),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 press, 1 release, 2 long, 3 repeat
        int key;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Event expected `ms` after an input edge driven at cycle c0 (sync + tick jitter).
    task automatic push_evt(input int kind, input int key, input int c0, input int ms);
        exp_t e;
        e.kind = kind;
        e.key  = key;
        e.lo   = c0 + ms * CPM - 8;
        e.hi   = c0 + ms * CPM + 6;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] v;
        exp_t       e;
        for (int i = 0; i < NK; i++) begin
            v = {key_repeat[i], long_press[i], key_release[i], press[i]};
            for (int k = 0; k < 4; k++) begin
                if (v[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: got kind=%0d key=%0d at cyc=%0d, expected none",
                                 k, i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.key != i || cyc < e.lo || cyc > e.hi) begin
                            failures++;
                            $display("FAIL event: got kind=%0d key=%0d cyc=%0d, expected kind=%0d key=%0d cyc=[%0d,%0d]",
                                     k, i, cyc, e.kind, e.key, e.lo, e.hi);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst    = 1'b1;
        key_in = '0;
        wait_cycles(5);
        checks++;
        if (key_level !== 5'b0) begin
            failures++; $display("FAIL reset_level: got %b, expected 00000", key_level);
        end
        checks++;
        if (press !== 5'b0) begin
            failures++; $display("FAIL reset_press: got %b, expected 00000", press);
        end
        checks++;
        if (key_release !== 5'b0) begin
            failures++; $display("FAIL reset_release: got %b, expected 00000", key_release);
        end
        checks++;
        if (long_press !== 5'b0) begin
            failures++; $display("FAIL reset_long: got %b, expected 00000", long_press);
        end
        checks++;
        if (key_repeat !== 5'b0) begin
            failures++; $display("FAIL reset_repeat: got %b, expected 00000", key_repeat);
        end
        rst = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_clean_press();
        key_in[0] = 1'b1;
        push_evt(0, 0, cyc, 20);
        wait_cycles(500);
        checks++;
        if (key_level !== 5'b00001) begin
            failures++; $display("FAIL clean_level_held: got %b, expected 00001", key_level);
        end
        key_in[0] = 1'b0;
        push_evt(1, 0, cyc, 20);
        wait_cycles(300);
        checks++;
        if (key_level !== 5'b0) begin
            failures++; $display("FAIL clean_level_released: got %b, expected 00000", key_level);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL clean_missing_events: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_bouncy();
        for (int p = 0; p < 4; p++) begin
            key_in[0] = (p % 2 == 0);
            wait_cycles(5 * CPM);
        end
        key_in[0] = 1'b1;
        push_evt(0, 0, cyc, 20);
        wait_cycles(400);
        checks++;
        if (key_level !== 5'b00001) begin
            failures++; $display("FAIL bouncy_level: got %b, expected 00001", key_level);
        end
        key_in[0] = 1'b0;
        push_evt(1, 0, cyc, 20);
        wait_cycles(300);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL bouncy_missing_events: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_long_repeat();
        int c0;
        c0 = cyc;
        key_in[2] = 1'b1;
        push_evt(0, 2, c0, 20);
        push_evt(2, 2, c0, 120);
`ifdef KEY_REPEAT_EN
        push_evt(3, 2, c0, 150);
        push_evt(3, 2, c0, 180);
        push_evt(3, 2, c0, 210);
`endif
        wait_cycles(2200);
        checks++;
        if (key_level !== 5'b00100) begin
            failures++; $display("FAIL long_level: got %b, expected 00100", key_level);
        end
        key_in[2] = 1'b0;
        push_evt(1, 2, cyc, 20);
        wait_cycles(300);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL long_missing_events: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        c0 = cyc;
        key_in = 5'b01010;
        push_evt(0, 1, c0, 20);
        push_evt(0, 3, c0, 20);
        wait_cycles(400);
        key_in[1] = 1'b0;
        wait_cycles(3 * CPM);
        key_in[1] = 1'b1;
        wait_cycles(200);
        checks++;
        if (key_level !== 5'b01010) begin
            failures++; $display("FAIL glitch_level: got %b, expected 01010", key_level);
        end
        c0 = cyc;
        key_in = '0;
        push_evt(1, 1, c0, 20);
        push_evt(1, 3, c0, 20);
        wait_cycles(300);
        checks++;
        if (key_level !== 5'b0) begin
            failures++; $display("FAIL simul_level_released: got %b, expected 00000", key_level);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL simul_missing_events: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = cyc;
        key_in[4] = 1'b1;
        push_evt(0, 4, c0, 20);
        push_evt(2, 4, c0, 120);
`ifdef KEY_REPEAT_EN
        push_evt(3, 4, c0, 150);
`endif
        wait_cycles(1700);
        checks++;
        if (key_level !== 5'b10000) begin
            failures++; $display("FAIL mid_level_before_rst: got %b, expected 10000", key_level);
        end
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        checks++;
        if ({key_level, press, key_release, long_press, key_repeat} !== 25'b0) begin
            failures++;
            $display("FAIL mid_rst_outputs: got lvl=%b prs=%b rel=%b lng=%b rep=%b, expected all 0",
                     key_level, press, key_release, long_press, key_repeat);
        end
        push_evt(0, 4, cyc, 20);
        wait_cycles(400);
        checks++;
        if (key_level !== 5'b10000) begin
            failures++; $display("FAIL mid_repress_level: got %b, expected 10000", key_level);
        end
        key_in[4] = 1'b0;
        push_evt(1, 4, cyc, 20);
        wait_cycles(300);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL mid_missing_events: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_in = '0;
        test_reset();
        test_clean_press();
        test_bouncy();
        test_long_repeat();
        test_simultaneous();
        test_reset_mid();
        wait_cycles(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter N_KEYS, default 5, number of independent key channels.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, required stable time in ms.
REQ-004 SHALL have parameter LONG_MS, default 1000, hold time for a long-press event in ms.
REQ-005 SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms.
REQ-006 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port key_in, input, N_KEYS, raw asynchronous buttons, active-high.
REQ-009 SHALL have port key_level, output, N_KEYS, debounced level per key.
REQ-010 SHALL have port press, output, N_KEYS, one-cycle pulse on debounced press.
REQ-011 SHALL have port release, output, N_KEYS, one-cycle pulse on debounced release.
REQ-012 SHALL have port long_press, output, N_KEYS, one-cycle pulse once per hold reaching LONG_MS.
REQ-013 SHALL have port repeat, output, N_KEYS, one-cycle auto-repeat pulses.

Function
REQ-014 SHALL synchronise each key_in bit through two flops before any use.
REQ-015 SHALL generate a shared 1 ms tick: counter 0..CLK_HZ/1000-1, tick high for one clk at the terminal count.
REQ-016 SHALL run one FSM per key with states IDLE, DB_PRESS, HELD, LONG, DB_RELEASE.
REQ-017 SHALL move IDLE->DB_PRESS when the synced input is 1, and DB_PRESS->IDLE with no event on any 0 sample.
REQ-018 SHALL move DB_PRESS->HELD after DEBOUNCE_MS consecutive ticks of synced 1, setting key_level=1 and pulsing press in that same cycle.
REQ-019 SHALL count ticks in HELD; at LONG_MS ticks go HELD->LONG and pulse long_press exactly once.
REQ-020 SHALL, in LONG with KEY_REPEAT_EN defined, pulse repeat every REPEAT_MS ticks, first pulse REPEAT_MS after long_press.
REQ-021 SHALL move HELD or LONG->DB_RELEASE on synced 0, keeping key_level=1 and resetting the hold and repeat counters.
REQ-022 SHALL, in DB_RELEASE, return to the prior held state on any synced 1 with the hold count restarting from 0 and no event, and on DEBOUNCE_MS consecutive ticks of synced 0 go to IDLE, clear key_level and pulse release.
REQ-023 SHALL saturate every counter; widths are clog2 of the maximum count plus 1; no wrap-around.
REQ-024 SHALL keep channels fully independent; simultaneous events on different keys all pulse in the same cycle.
REQ-025 SHALL never assert press and release for one key in the same cycle.
REQ-026 SHALL have latency from a clean input edge to press/release of 2 sync cycles plus DEBOUNCE_MS ticks, with up to one tick period of jitter.

Reset
REQ-027 SHALL, on rst, clear all outputs to 0, all FSMs to IDLE, all counters and sync flops to 0.
REQ-028 SHALL apply reset asserted mid-operation immediately with no release pulse; a key still held after reset produces a fresh press after full debounce.

Configuration
REQ-029 SHALL implement auto-repeat only when macro KEY_REPEAT_EN is defined; otherwise repeat is tied to 0, the repeat counter is not built, and LONG holds silently until release.

Structure
REQ-030 SHALL place the FSM state encodings and the ms-tick divider constant in shared package/header stopwatch_pkg.
REQ-031 SHALL implement one channel as sub-module key_event_ch, instantiated N_KEYS times by generate, sharing the single tick.

Verification
REQ-032 SHALL cover, with CLK_HZ=10_000 (tick every 10 clk), DEBOUNCE_MS=20, LONG_MS=100, REPEAT_MS=30, the scenarios below.
REQ-033 Clean press on key 0 held 50 ms -> press pulse about 200 clk after the edge, key_level=1, release pulse about 200 clk after the falling edge, no long_press.
REQ-034 Bouncy press toggling every 5 ms for 15 ms then stable 1 -> exactly one press pulse, 20 ms after the last bounce.
REQ-035 Hold key 2 for 200 ms with KEY_REPEAT_EN defined -> long_press at 100 ms of hold, repeat at 130, 160, 190 ms; without the macro, repeat stays 0.
REQ-036 Keys 1 and 3 pressed in the same cycle -> both press bits high in one cycle; 3 ms low glitch while held -> no release and no second press.
REQ-037 Assert rst for 1 cycle while key 4 is held at 150 ms -> all outputs 0 next cycle, no release, then a new press 20 ms later.
